// File: rtl/frame_stream_ctrl.sv
// Frame sequencer between the pixel source and the AXI-Stream master: feeds
// height x width pixels tagged with sof/eol/eof, honouring back-pressure on both sides.
//
// state  | meaning
// IDLE   | waiting for start; dims latched when start is seen
// CFG    | one cycle: reject zero dims or clear the input counters
// STREAM | accepting pixels until the one carrying eof
// DRAIN  | waiting for the master to take the eof pixel
// DONE   | one cycle: frame_done pulse
module frame_stream_ctrl #(
    parameter int DIM_W = 12,
    parameter int PIX_W = 24
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_in_valid,
    output logic             pix_in_ready,
    output logic [PIX_W-1:0] rgb_out,
    output logic             rgb_valid,
    input  logic             datapath_ready,
    output logic             sof,
    output logic             eol,
    output logic             eof,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DIM_W-1:0] width_q, height_q;
    logic [DIM_W-1:0] in_col_q, in_row_q;
    logic             busy_st;
    logic             flush;
    logic             dims_zero;
    logic             in_xfer;
    logic             out_xfer;
    logic             in_sof, in_eol, in_eof;

    assign busy_st   = (state_q == S_CFG) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    // abort only has an effect while a frame is in flight
    assign flush     = abort && busy_st;
    assign dims_zero = (width_q == '0) || (height_q == '0);

    assign pix_in_ready = (state_q == S_STREAM) && (!rgb_valid || datapath_ready);
    assign in_xfer      = pix_in_valid && pix_in_ready;
    assign out_xfer     = rgb_valid && datapath_ready;

    // tags come from the counters before they advance
    assign in_sof = (in_col_q == '0) && (in_row_q == '0);
    assign in_eol = (in_col_q == width_q - DIM_W'(1));
    assign in_eof = in_eol && (in_row_q == height_q - DIM_W'(1));

    assign busy       = busy_st;
    assign frame_done = (state_q == S_DONE);
    assign cfg_err    = (state_q == S_CFG) && dims_zero;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CFG;
            S_CFG:    state_d = dims_zero ? S_IDLE : S_STREAM;
            S_STREAM: if (in_xfer && in_eof) state_d = S_DRAIN;
            S_DRAIN:  if (out_xfer && eof) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            width_q  <= '0;
            height_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            width_q  <= img_width;
            height_q <= img_height;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN || flush || state_q == S_CFG) begin
            in_col_q <= '0;
            in_row_q <= '0;
        end else if (in_xfer) begin
            if (in_eol) begin
                in_col_q <= '0;
                in_row_q <= in_row_q + DIM_W'(1);
            end else begin
                in_col_q <= in_col_q + DIM_W'(1);
            end
        end
    end

    // output register: loading wins over draining so a stall costs no bubble
    always_ff @(posedge clk) begin
        if (!resetN || flush) begin
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            col       <= '0;
            row       <= '0;
        end else if (in_xfer) begin
            rgb_out   <= pix_in;
            rgb_valid <= 1'b1;
            sof       <= in_sof;
            eol       <= in_eol;
            eof       <= in_eof;
            col       <= in_col_q;
            row       <= in_row_q;
        end else if (datapath_ready) begin
            rgb_valid <= 1'b0;
        end
    end

endmodule

// File: doc/frame_stream_ctrl.md
# frame_stream_ctrl

Frame sequencer that sits between the pixel source (frame buffer / line reader) and the AXI-Stream master of the video-enhancement datapath. It accepts a start command with the frame dimensions, then feeds exactly height×width pixels into the master's pixel port. Each pixel is tagged with start-of-frame, end-of-line and end-of-frame markers. It honours back-pressure on both sides and reports frame completion or configuration errors.

## Interface
- DIM_W, 12, width of dimension and coordinate buses (max 4095×4095)
- PIX_W, 24, pixel width (RGB 8:8:8)
- clk  in  1  clock; all logic on rising edge
- resetN  in  1  reset, synchronous, active-low
- start  in  1  one-cycle frame start request; sampled only in IDLE
- abort  in  1  level; terminates the current frame
- img_width  in  DIM_W  pixels per line; latched on accepted start
- img_height  in  DIM_W  lines per frame; latched on accepted start
- pix_in  in  PIX_W  source pixel
- pix_in_valid  in  1  source pixel valid
- pix_in_ready  out  1  controller accepts pix_in this cycle
- rgb_out  out  PIX_W  pixel to AXI-Stream master
- rgb_valid  out  1  rgb_out valid
- datapath_ready  in  1  master accepts rgb_out this cycle
- sof  out  1  qualifies rgb_out as pixel (0,0)
- eol  out  1  qualifies rgb_out as last pixel of a line
- eof  out  1  qualifies rgb_out as last pixel of the frame
- col  out  DIM_W  column of the pixel in rgb_out
- row  out  DIM_W  row of the pixel in rgb_out
- busy  out  1  high in CFG/STREAM/DRAIN
- frame_done  out  1  one-cycle pulse: last pixel handed to master
- cfg_err  out  1  one-cycle pulse: start with zero width or height

## Operation
- States: IDLE, CFG, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 → latch dims → CFG.
  - Other inputs are ignored.
- CFG (1 cycle):
  - Either latched dim = 0 → cfg_err pulse, → IDLE.
  - Otherwise clear the input counters (in_col, in_row) → STREAM.
- Input transfer: occurs on pix_in_valid && pix_in_ready.
- Output register:
  - Holds pixel, sof/eol/eof and col/row.
  - Loaded on each input transfer.
  - rgb_valid set on load and cleared when datapath_ready && !load.
  - rgb_out and the tags hold stable while rgb_valid && !datapath_ready.
- pix_in_ready = (state==STREAM) && (!rgb_valid || datapath_ready).
- Counters advance on input transfer:
  - in_col increments; at width-1 it wraps to 0 and in_row increments.
  - Tags are computed from the pre-increment values:
    - sof = (col==0 && row==0)
    - eol = (col==width-1)
    - eof = eol && (row==height-1)
- STREAM → DRAIN on the input transfer that carries eof; no further pixels are accepted.
- DRAIN: waits for rgb_valid && datapath_ready with eof → DONE.
- DONE (1 cycle): frame_done=1, → IDLE.
- abort=1 in CFG/STREAM/DRAIN:
  - Next cycle: state IDLE, rgb_valid=0, counters cleared.
  - No frame_done is issued; a pending output pixel is discarded.
- start outside IDLE is ignored; dimension changes outside IDLE are ignored.
- Width×height does not need to be computed; end detection uses row/col compares only.

## Timing
- Reset values: pix_in_ready=0, rgb_valid=0, rgb_out=0, sof=eol=eof=0, col=row=0, busy=0, frame_done=0, cfg_err=0, state IDLE.
- Reset mid-frame behaves as abort and takes priority over all inputs.
- start at cycle t → CFG at t+1 → pix_in_ready may first be high at t+2.
- Pixel latency: input transfer at t → rgb_valid/rgb_out at t+1.
- Full throughput: with continuous pix_in_valid and datapath_ready, 1 pixel/cycle; frame of N pixels ends with frame_done exactly N+3 cycles after start.
- Back-pressure with no bubble: output accepted and new pixel loaded in the same cycle.
- Last pixel accepted at t → frame_done at t+1, IDLE at t+2; a start at t+2 is accepted.
- abort and start in the same cycle while in IDLE: start wins; abort matters only while busy.
- 1×1 frame: single pixel with sof=eol=eof=1.

## Test plan
- 4×3 frame, always valid/ready:
  - 12 pixels out in order.
  - sof only on the first pixel; eol on cols 3 of rows 0..2; eof on the 12th pixel.
  - frame_done 15 cycles after start.
- Same frame, datapath_ready toggling every cycle and pix_in_valid low every 3rd cycle:
  - Output sequence identical.
  - rgb_out/tags stable while stalled.
  - No pixel lost or duplicated.
- start with width=0, height=5:
  - cfg_err pulse at start+1; busy low at start+2.
  - pix_in_ready never asserts.
- 1×1 frame:
  - One pixel with sof=eol=eof=1; frame_done follows its acceptance.
  - Back-to-back start at the first IDLE cycle accepted.
- abort after 5 pixels of 8×8:
  - Next cycle rgb_valid=0 and busy=0; no frame_done.
  - A subsequent 2×2 frame starts with sof at col 0, row 0.
- resetN low mid-frame for 1 cycle: all outputs at reset values next cycle; start during STREAM ignored.
